spm_seq_ctrl: RTL and testbench

- Sequencer that wraps the serial-parallel multiplier (SPM) array: accepts a parallel operand pair over valid/ready, holds the multiplicand on the SPM's parallel input, streams the multiplier LSB-first, and deserialises the SPM's serial product into a 2*WIDTH-bit word.
- Sits directly upstream (feeds x/y, clears the array) and downstream (consumes p) of the SPM.
- Gives the rest of the design a word-level multiply.

---
 rtl/spm_ctrl_pkg.sv | 16 +
 rtl/spm_ysr.sv | 41 ++++
 rtl/spm_seq_ctrl.sv | 113 +++++++++++
 tb/tb_spm_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
// Shared types and sizing helpers for the SPM sequencer.
package spm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Wide enough to reach 2*WIDTH+SPM_LAT, one past the last RUN count.
    function automatic int cnt_width(input int width, input int spm_lat);
        return $clog2(2 * width + spm_lat + 1);
    endfunction

endpackage

// File: rtl/spm_ysr.sv
// Multiplier PISO shifter: parallel load, LSB-first shift-out, fixed fill bit
// shifted in from the top once the loaded operand is exhausted.
module spm_ysr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic             fill_q, fill_d;

    always_comb begin
        sr_d   = sr_q;
        fill_d = fill_q;
        if (load_i) begin
            sr_d   = data_i;
            fill_d = fill_i;
        end else if (shift_i) begin
            sr_d = {fill_q, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            fill_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

    assign bit_o = sr_q[0];

endmodule

// File: rtl/spm_seq_ctrl.sv
// Word-level wrapper around the serial-parallel multiplier array.
// Optional build macro SPM_SIGNED_Y_EN: sign-extend the multiplier (signed x signed).
module spm_seq_ctrl
    import spm_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SPM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic               spm_rst,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    input  logic               spm_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int             CNT_W    = cnt_width(WIDTH, SPM_LAT);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(SPM_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH + SPM_LAT - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ysr_load, ysr_shift, ysr_bit, y_fill;

`ifdef SPM_SIGNED_Y_EN
    assign y_fill = mp[WIDTH-1];
`else
    assign y_fill = 1'b0;
`endif

    spm_ysr #(.WIDTH(WIDTH)) u_ysr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ysr_load),
        .shift_i (ysr_shift),
        .fill_i  (y_fill),
        .data_i  (mp),
        .bit_o   (ysr_bit)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        prod_d    = prod_q;
        ysr_load  = 1'b0;
        ysr_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = mc;
                    cnt_d    = '0;
                    ysr_load = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                ysr_shift = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // The first SPM_LAT p bits predate the first y bit and are dropped.
                if (cnt_q >= CNT_LAT) begin
                    prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            prod_q  <= prod_d;
        end
    end

    // Combinational reset term lets the array clear in the same cycles as us.
    assign spm_rst   = ~rst_n | (state_q == CLEAR);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign spm_y     = (state_q == RUN) & ysr_bit;
    assign spm_x     = x_q;
    assign product   = prod_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed bench for spm_seq_ctrl at WIDTH=8 with a behavioural SPM array.
module tb_spm_seq_ctrl;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           spm_rst;
    logic [W-1:0]   spm_x;
    logic           spm_y;
    logic           spm_p;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    spm_seq_ctrl #(.WIDTH(W), .SPM_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mc        (mc),
        .mp        (mp),
        .spm_rst   (spm_rst),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SPM: accumulate x*y_k, emit the LSB, shift right; one-cycle latency.
    logic signed [2*W+1:0] spm_acc;
    logic signed [2*W+1:0] spm_sum;
    assign spm_sum = spm_acc + (spm_y ? {{(W+2){spm_x[W-1]}}, spm_x} : '0);

    always @(posedge clk) begin
        if (spm_rst) begin
            spm_acc <= '0;
            spm_p   <= 1'b0;
        end else begin
            spm_p   <= spm_sum[0];
            spm_acc <= spm_sum >>> 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call right after the accept edge (controller in CLEAR). Returns with out_valid seen.
    task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] exp);
        logic [2*W:0] ystr;
        logic [2*W:0] yexp;
        logic         fill;
        int           n;
`ifdef SPM_SIGNED_Y_EN
        fill = b[W-1];
`else
        fill = 1'b0;
`endif
        yexp = {{(W+1){fill}}, b};
        ystr = '0;
        check({tag, ".clr_rst"}, 64'(spm_rst), 64'd1);
        check({tag, ".spm_x"}, 64'(spm_x), 64'(a));
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
            if (!out_valid && n <= 2*W+1) ystr[n-1] = spm_y;
        end
        check({tag, ".latency"}, 64'(n), 64'd18);
        check({tag, ".ystream"}, 64'(ystr), 64'(yexp));
        check({tag, ".product"}, 64'(product), 64'(exp));
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        mc = a;
        mp = b;
        tick();
        in_valid = 1'b0;
        mc = 8'h5A;
        mp = 8'hC3;
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        accept(a, b);
        wait_done(tag, a, b, exp);
        handoff(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mc        = '0;
        mp        = '0;
        tick();
        tick();
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.product", 64'(product), 64'd0);
        check("rst.spm_x", 64'(spm_x), 64'd0);
        check("rst.spm_y", 64'(spm_y), 64'd0);
        check("rst.spm_rst", 64'(spm_rst), 64'd1);
        rst_n = 1'b1;
        #1;
        check("rst.spm_rst_rel", 64'(spm_rst), 64'd0);

`ifdef SPM_SIGNED_Y_EN
        run_op("op50x206", 8'd50, 8'd206, 16'hF63C);
        run_op("opFDxFB",  8'hFD, 8'hFB,  16'h000F);
        run_op("op80xFF",  8'h80, 8'hFF,  16'h0080);
`else
        run_op("op50x206", 8'd50, 8'd206, 16'h283C);
        run_op("opFDxFB",  8'hFD, 8'hFB,  16'hFD0F);
        run_op("op80xFF",  8'h80, 8'hFF,  16'h8080);
`endif
        run_op("opFDx05", 8'hFD, 8'h05, 16'hFFF1);
        run_op("mc_zero", 8'h00, 8'hAB, 16'h0000);
        run_op("mp_zero", 8'h12, 8'h00, 16'h0000);

        // Back-pressure in DONE, with a stray in_valid that must be ignored.
        accept(8'h7F, 8'h03);
        wait_done("bp", 8'h7F, 8'h03, 16'h017D);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.product", 64'(product), 64'h017D);
            check("bp.in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handoff("bp");

        // Reset in RUN at cnt=6: CLEAR cycle, then cnt0 .. cnt6.
        accept(8'h55, 8'hAA);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst.spm_rst", 64'(spm_rst), 64'd1);
        tick();
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.product", 64'(product), 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst.spm_rst_rel", 64'(spm_rst), 64'd0);
        run_op("op7x9", 8'd7, 8'd9, 16'h003F);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mc = 8'h7F;
        mp = 8'hFF;
        check("b2b.rdy0", 64'(in_ready), 64'd1);
        tick();
        mc = 8'h80;
        mp = 8'h01;
`ifdef SPM_SIGNED_Y_EN
        wait_done("b2b1", 8'h7F, 8'hFF, 16'hFF81);
`else
        wait_done("b2b1", 8'h7F, 8'hFF, 16'h7E81);
`endif
        tick();
        check("b2b.handoff_ov", 64'(out_valid), 64'd0);
        check("b2b.handoff_rdy", 64'(in_ready), 64'd1);
        tick();
        check("b2b.accept2", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_done("b2b2", 8'h80, 8'h01, 16'hFF80);
        tick();
        out_ready = 1'b0;
        check("b2b.idle", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
